// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: folds the fetch-side and load/store-side SRAM-like
// request/response ports into one AXI3 master. Reads share a single AR slot
// (data side has priority), stores go out on AW/W/B, and R/B beats are routed
// back to the requester by ID. At most one fetch and one data transaction
// are outstanding at any time.
module sram_axi_bridge (
   input  logic        clk,
   input  logic        reset,
   // instruction side
   input  logic        inst_sram_req,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   // data side
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   // AXI read address
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI read data
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   // AXI write address
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   // AXI write data
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // AXI write response
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   localparam logic [3:0] ID_INST = 4'd0;
   localparam logic [3:0] ID_DATA = 4'd1;

   typedef enum logic {AR_IDLE, AR_WAIT} ar_state_e;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

   ar_state_e   ar_state_q;
   logic [31:0] ar_addr_q;
   logic [3:0]  ar_id_q;
   logic [1:0]  ar_size_q;

   w_state_e    w_state_q;
   logic        aw_vld_q;
   logic        w_vld_q;
   logic [31:0] aw_addr_q;
   logic [1:0]  aw_size_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;

   logic        inst_pend_q, inst_pend_d;
   logic        data_pend_q, data_pend_d;

   logic        inst_rsp, data_rsp;
   logic        inst_free, data_free;
   logic        ar_idle, w_idle_eff, wr_hazard;
   logic        data_rd_elig, data_wr_elig, inst_elig, inst_grant;
   logic        data_rd_acc, data_wr_acc, inst_acc;

   // Status/response fields carry nothing the requesters can act on.
   logic        unused_rsp;
   assign unused_rsp = ^{rresp, rlast, bresp, bid};

   // Response decode: a pending slot is considered free in the very cycle its
   // response arrives, so a follow-on request can be accepted back-to-back.
   always_comb begin
      inst_rsp   = rvalid && (rid == ID_INST);
      data_rsp   = (rvalid && (rid == ID_DATA)) || bvalid;
      inst_free  = !inst_pend_q || inst_rsp;
      data_free  = !data_pend_q || data_rsp;
      ar_idle    = (ar_state_q == AR_IDLE);
      w_idle_eff = (w_state_q == W_IDLE) || ((w_state_q == W_RESP) && bvalid);
      // A fetch must not overtake a store still in flight to the same word.
      wr_hazard  = !w_idle_eff && (inst_sram_addr[31:2] == aw_addr_q[31:2]);
   end

   // Arbitration: data-side read beats fetch for the single AR slot.
   always_comb begin
      data_rd_elig = data_sram_req && !data_sram_wr && ar_idle && data_free;
      data_wr_elig = data_sram_req && data_sram_wr && w_idle_eff && data_free;
      inst_elig    = inst_sram_req && ar_idle && inst_free && !wr_hazard;
      inst_grant   = inst_elig && !data_rd_elig;
      data_rd_acc  = !reset && data_rd_elig;
      data_wr_acc  = !reset && data_wr_elig;
      inst_acc     = !reset && inst_grant;
   end

   // Outstanding flags: a new accept wins over a clearing response.
   always_comb begin
      inst_pend_d = inst_pend_q;
      data_pend_d = data_pend_q;
      if (inst_rsp)
         inst_pend_d = 1'b0;
      if (inst_acc)
         inst_pend_d = 1'b1;
      if (data_rsp)
         data_pend_d = 1'b0;
      if (data_rd_acc || data_wr_acc)
         data_pend_d = 1'b1;
   end

   // Outstanding flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_pend_q <= 1'b0;
         data_pend_q <= 1'b0;
      end else begin
         inst_pend_q <= inst_pend_d;
         data_pend_q <= data_pend_d;
      end
   end

   // AR slot FSM: holds arvalid from the accept until the AR handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         ar_state_q <= AR_IDLE;
      end else begin
         case (ar_state_q)
            AR_IDLE: if (data_rd_acc || inst_acc) ar_state_q <= AR_WAIT;
            AR_WAIT: if (arready) ar_state_q <= AR_IDLE;
            default: ar_state_q <= AR_IDLE;
         endcase
      end
   end

   // AR slot payload, latched on the accepting edge.
   always_ff @(posedge clk) begin
      if (data_rd_acc) begin
         ar_addr_q <= data_sram_addr;
         ar_id_q   <= ID_DATA;
         ar_size_q <= data_sram_size;
      end else if (inst_acc) begin
         ar_addr_q <= inst_sram_addr;
         ar_id_q   <= ID_INST;
         ar_size_q <= inst_sram_size;
      end
   end

   // Store FSM: AW and W are offered together and retire independently;
   // the response phase starts once both have handshaken.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         aw_vld_q  <= 1'b0;
         w_vld_q   <= 1'b0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (data_wr_acc) begin
                  w_state_q <= W_SEND;
                  aw_vld_q  <= 1'b1;
                  w_vld_q   <= 1'b1;
               end
            end
            W_SEND: begin
               aw_vld_q <= aw_vld_q && !awready;
               w_vld_q  <= w_vld_q && !wready;
               if ((!aw_vld_q || awready) && (!w_vld_q || wready))
                  w_state_q <= W_RESP;
            end
            W_RESP: begin
               if (data_wr_acc) begin
                  w_state_q <= W_SEND;
                  aw_vld_q  <= 1'b1;
                  w_vld_q   <= 1'b1;
               end else if (bvalid) begin
                  w_state_q <= W_IDLE;
               end
            end
            default: begin
               w_state_q <= W_IDLE;
               aw_vld_q  <= 1'b0;
               w_vld_q   <= 1'b0;
            end
         endcase
      end
   end

   // Store payload, latched on the accepting edge.
   always_ff @(posedge clk) begin
      if (data_wr_acc) begin
         aw_addr_q <= data_sram_addr;
         aw_size_q <= data_sram_size;
         wdata_q   <= data_sram_wdata;
         wstrb_q   <= data_sram_wstrb;
      end
   end

   // Requester-facing handshakes and routed responses.
   always_comb begin
      inst_sram_addr_ok = inst_acc;
      data_sram_addr_ok = data_rd_acc || data_wr_acc;
      inst_sram_data_ok = !reset && inst_rsp;
      data_sram_data_ok = !reset && data_rsp;
      inst_sram_rdata   = rdata;
      data_sram_rdata   = rdata;
   end

   // AXI master signals; single-beat incrementing bursts only.
   always_comb begin
      arid    = ar_id_q;
      araddr  = ar_addr_q;
      arlen   = 4'd0;
      arsize  = {1'b0, ar_size_q};
      arburst = 2'b01;
      arlock  = 2'd0;
      arcache = 4'd0;
      arprot  = 3'd0;
      arvalid = (ar_state_q == AR_WAIT);
      rready  = !reset;
      awid    = ID_DATA;
      awaddr  = aw_addr_q;
      awlen   = 4'd0;
      awsize  = {1'b0, aw_size_q};
      awburst = 2'b01;
      awlock  = 2'd0;
      awcache = 4'd0;
      awprot  = 3'd0;
      awvalid = aw_vld_q;
      wid     = ID_DATA;
      wdata   = wdata_q;
      wstrb   = wstrb_q;
      wlast   = 1'b1;
      wvalid  = w_vld_q;
      bready  = !reset;
   end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed cycle tables, a reset sequence and a
// randomized run against a transaction-level model of the bridge and slave.
module tb_sram_axi_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr, inst_sram_rdata;
   logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
   logic [3:0]  arid, arlen, arcache;
   logic [31:0] araddr;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, arlock;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid, awlen, awcache;
   logic [31:0] awaddr;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock;
   logic        awvalid, awready;
   logic [3:0]  wid, wstrb;
   logic [31:0] wdata;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   always #5 clk = ~clk;

   sram_axi_bridge dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
      .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      inst_sram_req = 0; inst_sram_size = 2'd2; inst_sram_addr = 0;
      data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
      data_sram_wstrb = 4'hF; data_sram_addr = 0; data_sram_wdata = 32'hDEADBEEF;
      arready = 0; awready = 0; wready = 0;
      rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
      bid = 4'd1; bresp = 0; bvalid = 0;
   endtask

   // One directed cycle: inputs and the outputs expected during that cycle.
   typedef struct {
      string       nm;
      bit          ir;  logic [31:0] ia;
      bit          dr;  bit dw; logic [31:0] da;
      bit          arr; bit awr; bit wrr;
      bit          rv;  logic [3:0] ri; logic [31:0] rd;
      bit          bv;
      bit          e_iaok, e_daok, e_idok, e_ddok, e_arv;
      logic [3:0]  e_arid; logic [31:0] e_araddr;
      bit          e_awv, e_wv;
   } vec_t;

   function automatic vec_t V(input string nm, input bit ir, input logic [31:0] ia,
                              input bit dr, input bit dw, input logic [31:0] da,
                              input bit arr, input bit awr, input bit wrr,
                              input bit rv, input logic [3:0] ri, input logic [31:0] rd,
                              input bit bv, input bit eia, input bit eda, input bit eid,
                              input bit edd, input bit earv, input logic [3:0] eari,
                              input logic [31:0] eara, input bit eawv, input bit ewv);
      vec_t v;
      v.nm = nm; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
      v.arr = arr; v.awr = awr; v.wrr = wrr; v.rv = rv; v.ri = ri; v.rd = rd;
      v.bv = bv; v.e_iaok = eia; v.e_daok = eda; v.e_idok = eid; v.e_ddok = edd;
      v.e_arv = earv; v.e_arid = eari; v.e_araddr = eara; v.e_awv = eawv; v.e_wv = ewv;
      return v;
   endfunction

   vec_t vecs[$];

   // Slave/reference model state for the randomized run.
   typedef struct { logic [3:0] id; logic [31:0] addr; int due; } rsp_t;
   rsp_t        rq[$];
   int          b_due;
   bit          m_ar_busy; logic [3:0] m_ar_id; logic [31:0] m_ar_addr; logic [1:0] m_ar_size;
   bit          m_inst_out, m_data_out;
   logic [31:0] m_inst_addr, m_data_addr;
   bit          m_wr_pend, m_aw_out, m_w_out, m_b_sched;
   logic [31:0] m_wr_addr, m_wdata; logic [3:0] m_wstrb; logic [1:0] m_wsize;
   bit          r_i, r_d, d_resp, dfree, ifree, wblock, e_drd, e_dwr, e_iaok;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
   endfunction

   initial begin
      idle_inputs();
      b_due = -1;
      m_ar_busy = 0; m_inst_out = 0; m_data_out = 0;
      m_wr_pend = 0; m_aw_out = 0; m_w_out = 0; m_b_sched = 0;
      m_ar_id = 0; m_ar_addr = 0; m_ar_size = 0; m_inst_addr = 0; m_data_addr = 0;
      m_wr_addr = 0; m_wdata = 0; m_wstrb = 0; m_wsize = 0;

      // ---------------- reset: outputs quiet even with traffic on the inputs
      reset = 1;
      @(posedge clk); #1;
      inst_sram_req = 1; inst_sram_addr = 32'h1c000000;
      data_sram_req = 1; rvalid = 1; rid = 0; bvalid = 1;
      @(negedge clk);
      chk("rst arvalid", arvalid, 0);
      chk("rst awvalid", awvalid, 0);
      chk("rst wvalid", wvalid, 0);
      chk("rst rready", rready, 0);
      chk("rst bready", bready, 0);
      chk("rst inst_addr_ok", inst_sram_addr_ok, 0);
      chk("rst data_addr_ok", data_sram_addr_ok, 0);
      chk("rst inst_data_ok", inst_sram_data_ok, 0);
      chk("rst data_data_ok", data_sram_data_ok, 0);
      @(posedge clk); #1;
      idle_inputs();
      reset = 0;
      @(negedge clk);
      chk("rready", rready, 1);
      chk("bready", bready, 1);
      chk("const arlen/awlen", {arlen, awlen}, 8'h00);
      chk("const burst", {arburst, awburst}, 4'b0101);
      chk("const lock/cache/prot", {arlock, awlock, arcache, awcache, arprot, awprot}, 0);
      chk("const ids/wlast", {awid, wid, wlast}, 9'b0001_0001_1);
      @(posedge clk); #1;

      // ---------------- directed cycle tables
      // A: single fetch
      vecs.push_back(V("A0", 1,32'h1c000000, 0,0,0, 0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0, 0,0));
      vecs.push_back(V("A1", 0,0, 0,0,0, 1,0,0, 0,0,0,0, 0,0,0,0, 1,0,32'h1c000000, 0,0));
      vecs.push_back(V("A2", 0,0, 0,0,0, 0,0,0, 1,0,32'h02800400,0, 0,0,1,0, 0,0,0, 0,0));
      vecs.push_back(V("A3", 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      // B: simultaneous inst/data reads, out-of-order R beats
      vecs.push_back(V("B0", 1,32'h1c000010, 1,0,32'h1c002000, 0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0, 0,0));
      vecs.push_back(V("B1", 1,32'h1c000010, 0,0,0, 1,0,0, 0,0,0,0, 0,0,0,0, 1,1,32'h1c002000, 0,0));
      vecs.push_back(V("B2", 1,32'h1c000010, 0,0,0, 0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0, 0,0));
      vecs.push_back(V("B3", 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 1,0,32'h1c000010, 0,0));
      vecs.push_back(V("B4", 0,0, 0,0,0, 1,0,0, 0,0,0,0, 0,0,0,0, 1,0,32'h1c000010, 0,0));
      vecs.push_back(V("B5", 0,0, 0,0,0, 0,0,0, 1,0,32'hAAAA0001,0, 0,0,1,0, 0,0,0, 0,0));
      vecs.push_back(V("B6", 0,0, 0,0,0, 0,0,0, 1,1,32'hBBBB0002,0, 0,0,0,1, 0,0,0, 0,0));
      vecs.push_back(V("B7", 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      // C: store with AW early and W late
      vecs.push_back(V("C0", 0,0, 1,1,32'h1c001000, 0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0, 0,0));
      vecs.push_back(V("C1", 0,0, 0,0,0, 0,1,0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,1));
      vecs.push_back(V("C2", 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,1));
      vecs.push_back(V("C3", 0,0, 0,0,0, 0,0,1, 0,0,0,0, 0,0,0,0, 0,0,0, 0,1));
      vecs.push_back(V("C4", 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      vecs.push_back(V("C5", 0,0, 0,0,0, 0,0,0, 0,0,0,1, 0,0,0,1, 0,0,0, 0,0));
      vecs.push_back(V("C6", 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      // D: fetch blocked behind a store to the same word, other word passes
      vecs.push_back(V("D0", 0,0, 1,1,32'h1c001004, 0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0, 0,0));
      vecs.push_back(V("D1", 1,32'h1c001004, 0,0,0, 0,1,1, 0,0,0,0, 0,0,0,0, 0,0,0, 1,1));
      vecs.push_back(V("D2", 1,32'h1c001004, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      vecs.push_back(V("D3", 1,32'h1c001004, 0,0,0, 0,0,0, 0,0,0,1, 1,0,0,1, 0,0,0, 0,0));
      vecs.push_back(V("D4", 0,0, 0,0,0, 1,0,0, 0,0,0,0, 0,0,0,0, 1,0,32'h1c001004, 0,0));
      vecs.push_back(V("D5", 0,0, 0,0,0, 0,0,0, 1,0,32'h11110000,0, 0,0,1,0, 0,0,0, 0,0));
      vecs.push_back(V("D6", 0,0, 1,1,32'h1c001004, 0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0, 0,0));
      vecs.push_back(V("D7", 1,32'h1c001008, 0,0,0, 0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0, 1,1));
      vecs.push_back(V("D8", 0,0, 0,0,0, 1,1,1, 0,0,0,0, 0,0,0,0, 1,0,32'h1c001008, 1,1));
      vecs.push_back(V("D9", 0,0, 0,0,0, 0,0,0, 1,0,32'h22220000,0, 0,0,1,0, 0,0,0, 0,0));
      vecs.push_back(V("D10", 0,0, 0,0,0, 0,0,0, 0,0,0,1, 0,0,0,1, 0,0,0, 0,0));
      vecs.push_back(V("D11", 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      // E: second data request waits for the load's R beat
      vecs.push_back(V("E0", 0,0, 1,0,32'h1c003000, 0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0, 0,0));
      vecs.push_back(V("E1", 0,0, 1,0,32'h1c003004, 1,0,0, 0,0,0,0, 0,0,0,0, 1,1,32'h1c003000, 0,0));
      vecs.push_back(V("E2", 0,0, 1,0,32'h1c003004, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));
      vecs.push_back(V("E3", 0,0, 1,0,32'h1c003004, 0,0,0, 1,1,32'h33330000,0, 0,1,0,1, 0,0,0, 0,0));
      vecs.push_back(V("E4", 0,0, 0,0,0, 1,0,0, 0,0,0,0, 0,0,0,0, 1,1,32'h1c003004, 0,0));
      vecs.push_back(V("E5", 0,0, 0,0,0, 0,0,0, 1,1,32'h44440000,0, 0,0,0,1, 0,0,0, 0,0));
      vecs.push_back(V("E6", 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0));

      foreach (vecs[i]) begin
         inst_sram_req = vecs[i].ir;  inst_sram_addr = vecs[i].ia;
         data_sram_req = vecs[i].dr;  data_sram_wr = vecs[i].dw; data_sram_addr = vecs[i].da;
         arready = vecs[i].arr; awready = vecs[i].awr; wready = vecs[i].wrr;
         rvalid = vecs[i].rv; rid = vecs[i].ri; rdata = vecs[i].rd; bvalid = vecs[i].bv;
         @(negedge clk);
         chk({vecs[i].nm, " inst_addr_ok"}, inst_sram_addr_ok, vecs[i].e_iaok);
         chk({vecs[i].nm, " data_addr_ok"}, data_sram_addr_ok, vecs[i].e_daok);
         chk({vecs[i].nm, " inst_data_ok"}, inst_sram_data_ok, vecs[i].e_idok);
         chk({vecs[i].nm, " data_data_ok"}, data_sram_data_ok, vecs[i].e_ddok);
         chk({vecs[i].nm, " arvalid"}, arvalid, vecs[i].e_arv);
         chk({vecs[i].nm, " awvalid"}, awvalid, vecs[i].e_awv);
         chk({vecs[i].nm, " wvalid"}, wvalid, vecs[i].e_wv);
         if (vecs[i].e_arv) begin
            chk({vecs[i].nm, " arid"}, arid, vecs[i].e_arid);
            chk({vecs[i].nm, " araddr"}, araddr, vecs[i].e_araddr);
         end
         if (vecs[i].e_idok)
            chk({vecs[i].nm, " inst_rdata"}, inst_sram_rdata, vecs[i].rd);
         if (vecs[i].e_ddok)
            chk({vecs[i].nm, " data_rdata"}, data_sram_rdata, vecs[i].rd);
         @(posedge clk); #1;
      end
      idle_inputs();

      // ---------------- reset pulsed while arvalid is high
      inst_sram_req = 1; inst_sram_addr = 32'h1c000100;
      @(negedge clk);
      chk("R0 inst_addr_ok", inst_sram_addr_ok, 1);
      @(posedge clk); #1;
      inst_sram_req = 0;
      @(negedge clk);
      chk("R1 arvalid", arvalid, 1);
      @(posedge clk); #1;
      reset = 1; inst_sram_req = 1; rvalid = 1; rid = 0;
      @(negedge clk);
      chk("R2 inst_addr_ok in reset", inst_sram_addr_ok, 0);
      chk("R2 inst_data_ok in reset", inst_sram_data_ok, 0);
      @(posedge clk); #1;
      reset = 0; inst_sram_req = 0; rvalid = 0;
      @(negedge clk);
      chk("R3 arvalid after reset", arvalid, 0);
      chk("R3 inst_data_ok", inst_sram_data_ok, 0);
      @(posedge clk); #1;
      inst_sram_req = 1; inst_sram_addr = 32'h1c000200;
      @(negedge clk);
      chk("R4 inst_addr_ok", inst_sram_addr_ok, 1);
      @(posedge clk); #1;
      inst_sram_req = 0; arready = 1;
      @(negedge clk);
      chk("R5 arvalid", arvalid, 1);
      chk("R5 araddr", araddr, 32'h1c000200);
      @(posedge clk); #1;
      arready = 0; rvalid = 1; rid = 0; rdata = 32'h5555AAAA;
      @(negedge clk);
      chk("R6 inst_data_ok", inst_sram_data_ok, 1);
      chk("R6 arvalid", arvalid, 0);
      @(posedge clk); #1;
      idle_inputs();

      // ---------------- randomized traffic against the reference model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         inst_sram_req   = ($urandom_range(0, 2) != 0);
         inst_sram_addr  = 32'h1c001000 + 32'(4 * $urandom_range(0, 3));
         inst_sram_size  = 2'($urandom_range(0, 2));
         data_sram_req   = ($urandom_range(0, 1) != 0);
         data_sram_wr    = ($urandom_range(0, 1) != 0);
         data_sram_addr  = 32'h1c001000 + 32'(4 * $urandom_range(0, 3));
         data_sram_size  = 2'($urandom_range(0, 2));
         data_sram_wdata = $urandom;
         data_sram_wstrb = 4'($urandom_range(0, 15));
         arready = ($urandom_range(0, 1) != 0);
         awready = ($urandom_range(0, 1) != 0);
         wready  = ($urandom_range(0, 1) != 0);
         rresp = 2'($urandom_range(0, 3)); bresp = 2'($urandom_range(0, 3));
         rvalid = 0; rid = 0; rdata = $urandom;
         for (int k = 0; k < rq.size(); k++) begin
            if (rq[k].due <= cyc) begin
               rvalid = 1; rid = rq[k].id; rdata = mem(rq[k].addr);
               rq.delete(k);
               break;
            end
         end
         bvalid = (b_due >= 0) && (b_due <= cyc);
         if (bvalid) b_due = -1;

         @(negedge clk);
         r_i    = rvalid && (rid == 4'd0);
         r_d    = rvalid && (rid == 4'd1);
         d_resp = r_d || bvalid;
         dfree  = !m_data_out || d_resp;
         ifree  = !m_inst_out || r_i;
         wblock = m_wr_pend && !bvalid && (inst_sram_addr[31:2] == m_wr_addr[31:2]);
         e_drd  = data_sram_req && !data_sram_wr && !m_ar_busy && dfree;
         e_dwr  = data_sram_req && data_sram_wr && dfree;
         e_iaok = inst_sram_req && !m_ar_busy && ifree && !wblock && !e_drd;

         chk("rnd inst_addr_ok", inst_sram_addr_ok, e_iaok);
         chk("rnd data_addr_ok", data_sram_addr_ok, e_drd || e_dwr);
         chk("rnd inst_data_ok", inst_sram_data_ok, r_i);
         chk("rnd data_data_ok", data_sram_data_ok, d_resp);
         chk("rnd arvalid", arvalid, m_ar_busy);
         chk("rnd awvalid", awvalid, m_aw_out);
         chk("rnd wvalid", wvalid, m_w_out);
         if (m_ar_busy) begin
            chk("rnd arid", arid, m_ar_id);
            chk("rnd araddr", araddr, m_ar_addr);
            chk("rnd arsize", arsize, {1'b0, m_ar_size});
         end
         if (m_aw_out) begin
            chk("rnd awaddr", awaddr, m_wr_addr);
            chk("rnd awsize", awsize, {1'b0, m_wsize});
         end
         if (m_w_out) begin
            chk("rnd wdata", wdata, m_wdata);
            chk("rnd wstrb", wstrb, m_wstrb);
         end
         if (r_i) chk("rnd inst_rdata", inst_sram_rdata, mem(m_inst_addr));
         if (r_d) chk("rnd data_rdata", data_sram_rdata, mem(m_data_addr));

         if (m_ar_busy && arready) begin
            rq.push_back('{id: m_ar_id, addr: m_ar_addr, due: cyc + 1 + $urandom_range(0, 3)});
            m_ar_busy = 0;
         end
         if (m_aw_out && awready) m_aw_out = 0;
         if (m_w_out && wready) m_w_out = 0;
         if (m_wr_pend && !m_aw_out && !m_w_out && !m_b_sched) begin
            b_due = cyc + 1 + $urandom_range(0, 3);
            m_b_sched = 1;
         end
         if (bvalid) begin
            m_wr_pend = 0; m_b_sched = 0; m_data_out = 0;
         end
         if (r_i) m_inst_out = 0;
         if (r_d) m_data_out = 0;
         if (e_drd) begin
            m_ar_busy = 1; m_ar_id = 4'd1; m_ar_addr = data_sram_addr; m_ar_size = data_sram_size;
            m_data_out = 1; m_data_addr = data_sram_addr;
         end else if (e_iaok) begin
            m_ar_busy = 1; m_ar_id = 4'd0; m_ar_addr = inst_sram_addr; m_ar_size = inst_sram_size;
            m_inst_out = 1; m_inst_addr = inst_sram_addr;
         end
         if (e_dwr) begin
            m_wr_pend = 1; m_aw_out = 1; m_w_out = 1; m_data_out = 1;
            m_wr_addr = data_sram_addr; m_wsize = data_sram_size;
            m_wdata = data_sram_wdata; m_wstrb = data_sram_wstrb;
         end
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
